fmm_row_merge_engine: RTL and testbench

- Parametrised row-merge engine for the FMM reduce kernel.
- For each column c in [0, n_cols), reads A = M[a_base+c] and B = M[b_base+c] from the shared M_e memory.
- When both are nonzero and they match under the selected mode, zeroes both source entries and optionally writes A to M[d_base+c].
- Generalises the fixed 32-bit/17-bit column-merge loop with configurable widths, a runtime match mode, an optional destination write and a merge counter.

---
 rtl/fmm_merge_pkg.sv | 21 ++
 rtl/fmm_merge_cmp.sv | 37 +++
 rtl/fmm_row_merge_engine.sv | 183 ++++++++++++++++++
 tb/tb_fmm_row_merge_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmm_merge_pkg.sv
// Shared definitions for the FMM row-merge blocks.
// Match-mode encodings and the merge FSM state type.
package fmm_merge_pkg;

  localparam logic [1:0] MODE_EQ  = 2'b00;
  localparam logic [1:0] MODE_NEG = 2'b01;
  localparam logic [1:0] MODE_ANY = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CMP  = 3'd3,
    WR_A = 3'd4,
    WR_B = 3'd5,
    WR_D = 3'd6,
    DONE = 3'd7
  } state_t;

endpackage

// File: rtl/fmm_merge_cmp.sv
// Element match test for the FMM reduce kernels.
// Negation is checked in DATA_W+1 bits so MIN never matches MIN.
module fmm_merge_cmp
  import fmm_merge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] e1,
  input  logic [DATA_W-1:0] e2,
  input  logic [1:0]        mode,
  output logic              match
);

  logic signed [DATA_W:0] s1;
  logic signed [DATA_W:0] s2n;
  logic                   nz;
  logic                   eq;
  logic                   neg;

  // Both operands nonzero, then equality/negation per mode
  always_comb begin
    s1    = {e1[DATA_W-1], e1};
    s2n   = -$signed({e2[DATA_W-1], e2});
    nz    = (e1 != '0) && (e2 != '0);
    eq    = (e1 == e2);
    neg   = (s1 == s2n);
    match = 1'b0;
    unique case (mode)
      MODE_EQ:  match = nz && eq;
      MODE_NEG: match = nz && neg;
      MODE_ANY: match = nz && (eq || neg);
      MODE_OFF: match = 1'b0;
      default:  match = 1'b0;
    endcase
  end

endmodule

// File: rtl/fmm_row_merge_engine.sv
// Row-merge engine: zeroes matching A/B column pairs in M_e.
// FMM_ROW_MERGE_COUNT_EN enables the saturating match counter.
module fmm_row_merge_engine
  import fmm_merge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int COL_W  = 31
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [COL_W-1:0]  n_cols,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] d_base,
  input  logic [1:0]        mode,
  input  logic              dst_en,
  output logic [ADDR_W-1:0] M_e_address0,
  output logic              M_e_ce0,
  output logic              M_e_we0,
  output logic [DATA_W-1:0] M_e_d0,
  output logic [ADDR_W-1:0] M_e_address1,
  output logic              M_e_ce1,
  input  logic [DATA_W-1:0] M_e_q1,
  output logic [COL_W-1:0]  match_cnt
);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  n_r;
  logic [ADDR_W-1:0] a_r;
  logic [ADDR_W-1:0] b_r;
  logic [ADDR_W-1:0] d_r;
  logic [ADDR_W-1:0] col_a;
  logic [1:0]        mode_r;
  logic              dst_r;
  logic [DATA_W-1:0] e1;
  logic              match;
  logic              last;

  assign col_a = ADDR_W'(col);
  assign last  = (col + COL_W'(1)) == n_r;

  // e2 is consumed straight off the read port during CMP
  fmm_merge_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .e1    (e1),
    .e2    (M_e_q1),
    .mode  (mode_r),
    .match (match)
  );

  // Sequencer: latch the job, walk columns, branch on match
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      col    <= '0;
      n_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      d_r    <= '0;
      mode_r <= MODE_EQ;
      dst_r  <= 1'b0;
      e1     <= '0;
    end else begin
      unique case (state)
        IDLE: if (ap_start) begin
          n_r    <= n_cols;
          a_r    <= a_base;
          b_r    <= b_base;
          d_r    <= d_base;
          mode_r <= mode;
          dst_r  <= dst_en;
          col    <= '0;
          state  <= (n_cols == '0) ? DONE : RD_A;
        end
        RD_A: state <= RD_B;
        RD_B: begin
          e1    <= M_e_q1;
          state <= CMP;
        end
        CMP: begin
          if (match) begin
            state <= WR_A;
          end else if (last) begin
            state <= DONE;
          end else begin
            col   <= col + COL_W'(1);
            state <= RD_A;
          end
        end
        WR_A: state <= WR_B;
        WR_B: begin
          if (dst_r) begin
            state <= WR_D;
          end else if (last) begin
            state <= DONE;
          end else begin
            col   <= col + COL_W'(1);
            state <= RD_A;
          end
        end
        WR_D: begin
          if (last) begin
            state <= DONE;
          end else begin
            col   <= col + COL_W'(1);
            state <= RD_A;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FMM_ROW_MERGE_COUNT_EN
  logic [COL_W-1:0] cnt;

  // Saturating per-run count of merged columns
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt <= '0;
    end else if (state == IDLE && ap_start) begin
      cnt <= '0;
    end else if (state == CMP && match && cnt != '1) begin
      cnt <= cnt + COL_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

  // Memory port decode; reset drops enables in the same cycle
  always_comb begin
    ap_idle      = (state == IDLE);
    ap_done      = (state == DONE);
    ap_ready     = ap_done;
    M_e_address0 = '0;
    M_e_ce0      = 1'b0;
    M_e_we0      = 1'b0;
    M_e_d0       = '0;
    M_e_address1 = '0;
    M_e_ce1      = 1'b0;
    if (ap_rst_n) begin
      unique case (state)
        RD_A: begin
          M_e_ce1      = 1'b1;
          M_e_address1 = a_r + col_a;
        end
        RD_B: begin
          M_e_ce1      = 1'b1;
          M_e_address1 = b_r + col_a;
        end
        WR_A: begin
          M_e_ce0      = 1'b1;
          M_e_we0      = 1'b1;
          M_e_address0 = a_r + col_a;
        end
        WR_B: begin
          M_e_ce0      = 1'b1;
          M_e_we0      = 1'b1;
          M_e_address0 = b_r + col_a;
        end
        WR_D: begin
          M_e_ce0      = 1'b1;
          M_e_we0      = 1'b1;
          M_e_address0 = d_r + col_a;
          M_e_d0       = e1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmm_row_merge_engine.sv
// Directed bench for fmm_row_merge_engine.
// Honours FMM_ROW_MERGE_COUNT_EN for the match_cnt expectations.
module tb_fmm_row_merge_engine;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 17;
  localparam int COL_W  = 31;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;
  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef FMM_ROW_MERGE_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic              ap_clk;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [COL_W-1:0]  n_cols;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] d_base;
  logic [1:0]        mode;
  logic              dst_en;
  logic [ADDR_W-1:0] M_e_address0;
  logic              M_e_ce0;
  logic              M_e_we0;
  logic [DATA_W-1:0] M_e_d0;
  logic [ADDR_W-1:0] M_e_address1;
  logic              M_e_ce1;
  logic [DATA_W-1:0] M_e_q1;
  logic [COL_W-1:0]  match_cnt;

  int checks   = 0;
  int failures = 0;
  int clash    = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_d;

  fmm_row_merge_engine #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .n_cols       (n_cols),
    .a_base       (a_base),
    .b_base       (b_base),
    .d_base       (d_base),
    .mode         (mode),
    .dst_en       (dst_en),
    .M_e_address0 (M_e_address0),
    .M_e_ce0      (M_e_ce0),
    .M_e_we0      (M_e_we0),
    .M_e_d0       (M_e_d0),
    .M_e_address1 (M_e_address1),
    .M_e_ce1      (M_e_ce1),
    .M_e_q1       (M_e_q1),
    .match_cnt    (match_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // M_e model: registered read, DUT write wins over host write
  always @(posedge ap_clk) begin
    if (M_e_ce1) M_e_q1 <= mem[M_e_address1];
    if (M_e_ce0 && M_e_we0) mem[M_e_address0] <= M_e_d0;
    else if (h_we) mem[h_addr] <= h_d;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int addr, input logic [31:0] d);
    h_we   = 1'b1;
    h_addr = addr[ADDR_W-1:0];
    h_d    = d;
    @(negedge ap_clk);
    h_we   = 1'b0;
  endtask

  function automatic logic [31:0] rd(input int addr);
    logic [ADDR_W-1:0] a;
    a = addr[ADDR_W-1:0];
    return mem[a];
  endfunction

  task automatic run(input logic [COL_W-1:0] n,
                     input logic [ADDR_W-1:0] a,
                     input logic [ADDR_W-1:0] b,
                     input logic [ADDR_W-1:0] d,
                     input logic [1:0] m, input logic de,
                     input bit hold,
                     output int work, output int lat,
                     output int wrs, output bit ok,
                     output logic rdy);
    n_cols   = n;
    a_base   = a;
    b_base   = b;
    d_base   = d;
    mode     = m;
    dst_en   = de;
    ap_start = 1'b1;
    work = 0;
    lat  = 1;
    wrs  = 0;
    ok   = 1'b0;
    rdy  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ap_clk);
      lat++;
      if (!hold) ap_start = 1'b0;
      n_cols = 5;
      a_base = ~a;
      b_base = ~b;
      d_base = ~d;
      mode   = ~m;
      dst_en = ~de;
      if (M_e_ce0 && M_e_ce1) clash++;
      if (M_e_ce0) wrs++;
      if (ap_done) begin
        ok  = 1'b1;
        rdy = ap_ready;
        break;
      end
      if (!ap_idle) work++;
    end
    ap_start = 1'b0;
    chk("done_seen", ok, 1);
  endtask

  int   work;
  int   lat;
  int   wrs;
  bit   ok;
  logic rdy;
  bit   hit;

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    n_cols   = '0;
    a_base   = '0;
    b_base   = '0;
    d_base   = '0;
    mode     = 2'b00;
    dst_en   = 1'b0;
    h_we     = 1'b0;
    h_addr   = '0;
    h_d      = '0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_ce0", M_e_ce0, 0);
    chk("rst_we0", M_e_we0, 0);
    chk("rst_ce1", M_e_ce1, 0);
    chk("rst_addr0", M_e_address0, 0);
    chk("rst_addr1", M_e_address1, 0);
    chk("rst_d0", M_e_d0, 0);
    chk("rst_cnt", match_cnt, 0);

    // 1: zero columns
    run(0, 10, 20, 30, 2'b00, 1'b1, 1'b0, work, lat, wrs, ok, rdy);
    chk("t1_lat", lat, 2);
    chk("t1_work", work, 0);
    chk("t1_wrs", wrs, 0);
    chk("t1_ready", rdy, 1);
    chk("t1_cnt", match_cnt, 0);
    @(negedge ap_clk);
    chk("t1_idle", ap_idle, 1);

    // 2: equal mode, dst write on column 0 only
    poke(10, 5);  poke(11, 0);  poke(12, 7);
    poke(20, 5);  poke(21, 0);  poke(22, 8);
    poke(30, SENT); poke(31, SENT); poke(32, SENT);
    run(3, 10, 20, 30, 2'b00, 1'b1, 1'b0, work, lat, wrs, ok, rdy);
    chk("t2_work", work, 12);
    chk("t2_wrs", wrs, 3);
    chk("t2_a0", rd(10), 0);
    chk("t2_b0", rd(20), 0);
    chk("t2_d0", rd(30), 5);
    chk("t2_a2", rd(12), 7);
    chk("t2_b2", rd(22), 8);
    chk("t2_d1", rd(31), SENT);
    chk("t2_d2", rd(32), SENT);
    chk("t2_cnt", match_cnt, CNT_ON);

    // 3: negated mode, MIN vs MIN must not merge
    poke(110, 3);    poke(111, MINV);
    poke(210, -3);   poke(211, MINV);
    poke(310, SENT); poke(311, SENT);
    run(2, 110, 210, 310, 2'b01, 1'b1, 1'b0, work, lat, wrs, ok, rdy);
    chk("t3_work", work, 9);
    chk("t3_a0", rd(110), 0);
    chk("t3_b0", rd(210), 0);
    chk("t3_d0", rd(310), 3);
    chk("t3_a1", rd(111), MINV);
    chk("t3_b1", rd(211), MINV);
    chk("t3_d1", rd(311), SENT);
    chk("t3_cnt", match_cnt, CNT_ON);

    // 4: either mode, no destination write
    poke(100, 4);    poke(101, -4);
    poke(200, 4);    poke(201, 4);
    poke(300, SENT); poke(301, SENT);
    run(2, 100, 200, 300, 2'b10, 1'b0, 1'b0, work, lat, wrs, ok, rdy);
    chk("t4_work", work, 10);
    chk("t4_wrs", wrs, 4);
    chk("t4_a0", rd(100), 0);
    chk("t4_a1", rd(101), 0);
    chk("t4_b0", rd(200), 0);
    chk("t4_b1", rd(201), 0);
    chk("t4_d0", rd(300), SENT);
    chk("t4_d1", rd(301), SENT);
    chk("t4_cnt", match_cnt, 2 * CNT_ON);

    // never mode
    poke(120, 5); poke(220, 5);
    run(1, 120, 220, 320, 2'b11, 1'b1, 1'b0, work, lat, wrs, ok, rdy);
    chk("t7_work", work, 3);
    chk("t7_wrs", wrs, 0);
    chk("t7_a0", rd(120), 5);
    chk("t7_cnt", match_cnt, 0);

    // 5: reset during WR_B of column 1
    poke(1000, 1);    poke(1001, 2);
    poke(2000, 1);    poke(2001, 2);
    poke(3000, SENT); poke(3001, SENT);
    n_cols   = 2;
    a_base   = 1000;
    b_base   = 2000;
    d_base   = 3000;
    mode     = 2'b00;
    dst_en   = 1'b1;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (M_e_ce0 && M_e_address0 == 2001) begin
        hit = 1'b1;
        break;
      end
      @(negedge ap_clk);
    end
    chk("t5_reach_wrb", hit, 1);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("t5_idle", ap_idle, 1);
    chk("t5_ce0", M_e_ce0, 0);
    chk("t5_we0", M_e_we0, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("t5_a0", rd(1000), 0);
    chk("t5_d0", rd(3000), 1);
    chk("t5_a1", rd(1001), 0);
    chk("t5_b1", rd(2001), 2);
    chk("t5_d1", rd(3001), SENT);
    poke(1001, 9); poke(2001, 9);
    run(2, 1000, 2000, 3000, 2'b00, 1'b1, 1'b0, work, lat, wrs, ok, rdy);
    chk("t5r_work", work, 9);
    chk("t5r_d1", rd(3001), 9);
    chk("t5r_b1", rd(2001), 0);
    chk("t5r_d0", rd(3000), 1);
    chk("t5r_cnt", match_cnt, CNT_ON);

    // 6: address wrap with ap_start held high
    poke(32'h1FFFF, 6); poke(0, 7);
    poke(500, 6);       poke(501, 7);
    poke(600, SENT);    poke(601, SENT);
    run(2, 17'h1FFFF, 500, 600, 2'b00, 1'b1, 1'b1,
        work, lat, wrs, ok, rdy);
    chk("t6_work", work, 12);
    chk("t6_a0", rd(32'h1FFFF), 0);
    chk("t6_a1_wrap", rd(0), 0);
    chk("t6_b0", rd(500), 0);
    chk("t6_b1", rd(501), 0);
    chk("t6_d0", rd(600), 6);
    chk("t6_d1", rd(601), 7);
    repeat (4) @(negedge ap_clk);
    chk("t6_stay_idle", ap_idle, 1);
    chk("t6_cnt_hold", match_cnt, 2 * CNT_ON);
    chk("port_clash", clash, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
